fetch_controller: RTL



---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_queue.sv | 59 +++++
 rtl/fetch_controller.sv | 92 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int          WORD_BYTES   = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries; flush empties it and beats a same-cycle push.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t,
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  entry_t           wdata,
    output entry_t           rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic             pop_ok, push_ok;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A full queue still accepts a write when the head leaves in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + PTR_W'(1);
            if (pop_ok)  rptr <= rptr + PTR_W'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: drives imem, queues {instr, pc+4}, handshakes into IF/ID.
// Optional FETCH_PERF_EN adds push/redirect performance counters.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                INSTR_W     = 32,
    parameter int                QUEUE_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEF_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc_plus4
`ifdef FETCH_PERF_EN
   ,output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc_plus4;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc, pc_next, pc_inc;
    logic              push, pop, q_full, q_empty;
    logic [CNT_W-1:0]  q_count;
    entry_t            q_wdata, q_head;

    assign pc_inc    = fetch_pc + ADDR_W'(WORD_BYTES);
    assign imem_addr = fetch_pc;

    assign pop  = if_valid & if_ready;
    // Redirect wins: the word read this cycle belongs to the squashed path.
    assign push = ~branch_taken & (~q_full | pop);

    assign q_wdata = '{instr: imem_instr, pc_plus4: pc_inc};

    always_comb begin
        pc_next = fetch_pc;
        if (branch_taken) pc_next = branch_addr;
        else if (push)    pc_next = pc_inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fetch_pc <= RESET_PC;
        else        fetch_pc <= pc_next;
    end

    fetch_queue #(
        .DEPTH   (QUEUE_DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (branch_taken),
        .wdata (q_wdata),
        .rdata (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    // Storage is not reset, so the head is masked whenever nothing is queued.
    assign if_valid    = (q_count != '0);
    assign if_instr    = q_empty ? '0 : q_head.instr;
    assign if_pc_plus4 = q_empty ? '0 : q_head.pc_plus4;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (push)         perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (branch_taken) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule
